// File: rtl/md_unit_if.sv
// Multiply/divide unit bus: E-stage opcode and operands in, status and HI/LO out.
interface md_unit_if;
  logic [3:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        d_md_use;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  // Pipeline side: drives the E-stage opcode/operands and the D-stage usage flag
  modport master (
    output md_op, src_a, src_b, d_md_use,
    input  busy, stall, hi, lo
  );

  // Unit side
  modport slave (
    input  md_op, src_a, src_b, d_md_use,
    output busy, stall, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// The 64-bit result is computed on the start edge and held pending; HI/LO
// are committed when the fixed busy window expires. Divide by zero keeps the
// busy window but leaves HI/LO untouched.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  md_unit_if.slave  md_if
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [3:0] LP_MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] LP_DIV_CNT  = 4'(DIV_CYCLES);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  state_t      r_state;
  state_t      w_next_state;
  logic        w_start;
  logic        w_stall;
  logic        w_is_div;
  logic [3:0]  r_cnt;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic        r_div_zero;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic [63:0] w_result;

  // True for the four opcodes that launch a multi-cycle operation
  function automatic logic f_is_md_start(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Full {hi, lo} result of a mult/multu/div/divu. Signed divide works on
  // magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000 with no
  // overflow trap; a zero divisor is replaced by 1 since that result is
  // never committed.
  function automatic logic [63:0] f_md_result(
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [63:0] res;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] q;
    logic [31:0] r;
    res     = 64'd0;
    mag_a   = 32'd0;
    mag_b   = 32'd0;
    divisor = 32'd1;
    q       = 32'd0;
    r       = 32'd0;
    case (op)
      OP_MULT: begin
        res = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      end
      OP_MULTU: begin
        res = {32'd0, a} * {32'd0, b};
      end
      OP_DIV: begin
        mag_a   = a[31] ? (32'd0 - a) : a;
        mag_b   = b[31] ? (32'd0 - b) : b;
        divisor = (mag_b == 32'd0) ? 32'd1 : mag_b;
        q       = mag_a / divisor;
        r       = mag_a % divisor;
        if (a[31] ^ b[31]) begin
          q = 32'd0 - q;
        end else begin
          q = q;
        end
        if (a[31]) begin
          r = 32'd0 - r;
        end else begin
          r = r;
        end
        res = {r, q};
      end
      OP_DIVU: begin
        divisor = (b == 32'd0) ? 32'd1 : b;
        res     = {a % divisor, a / divisor};
      end
      default: begin
        res = 64'd0;
      end
    endcase
    return res;
  endfunction

  assign w_is_div = (md_if.md_op == OP_DIV) || (md_if.md_op == OP_DIVU);
  assign w_result = f_md_result(md_if.md_op, md_if.src_a, md_if.src_b);

  // Next-state, start detect and stall request
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (f_is_md_start(md_if.md_op)) begin
          w_start      = 1'b1;
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_cnt == 4'd1) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
    w_stall = md_if.d_md_use & (w_start | r_busy);
  end

  // State register with registered busy flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state == ST_RUN);
    end
  end

  // Counter, pending result capture and HI/LO commit / direct writes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= 4'd0;
      r_pend_hi  <= 32'd0;
      r_pend_lo  <= 32'd0;
      r_div_zero <= 1'b0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_pend_hi  <= w_result[63:32];
            r_pend_lo  <= w_result[31:0];
            r_cnt      <= w_is_div ? LP_DIV_CNT : LP_MULT_CNT;
            r_div_zero <= w_is_div && (md_if.src_b == 32'd0);
          end else if (md_if.md_op == OP_MTHI) begin
            r_hi <= md_if.src_a;
          end else if (md_if.md_op == OP_MTLO) begin
            r_lo <= md_if.src_a;
          end else begin
            r_cnt <= r_cnt;
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt - 4'd1;
          if ((r_cnt == 4'd1) && !r_div_zero) begin
            r_hi <= r_pend_hi;
            r_lo <= r_pend_lo;
          end else begin
            r_hi <= r_hi;
          end
        end
        default: begin
          r_cnt <= 4'd0;
        end
      endcase
    end
  end

  assign md_if.busy  = r_busy;
  assign md_if.stall = w_stall;
  assign md_if.hi    = r_hi;
  assign md_if.lo    = r_lo;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers for the 5-stage pipeline, sitting in the E stage beside the ALU.
- Sequences mult/multu/div/divu with fixed latencies and executes mthi/mtlo.
- Exports `busy`, `hi` and `lo`, plus a `stall` request that the hazard unit ORs into its D-stage freeze (`en=0`, E clear).

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low; asserted at 0
md_op  input  4  E-stage MD opcode: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7-15 treated as none
src_a  input  32  E-stage forwarded rs value
src_b  input  32  E-stage forwarded rt value
d_md_use  input  1  D-stage instruction is any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo
busy  output  1  operation in progress
stall  output  1  freeze request to hazard unit
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (reset=0, async): state IDLE, counter 0, pending HI/LO 0, hi=0, lo=0, busy=0. `stall` is combinational and follows the inputs. Reset mid-operation aborts it; the pending result is discarded.
- States: IDLE, RUN. 4-bit counter.
- start = (state==IDLE) & md_op in {1..4}. Combinational.
- IDLE, start:
  - On the edge, compute the 64-bit result into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- IDLE, md_op=5: hi<=src_a on the edge. md_op=6: lo<=src_a on the edge. State stays IDLE.
- RUN:
  - busy=1.
  - Counter decrements each edge.
  - On the edge where counter==1: hi<=pending_hi, lo<=pending_lo, state<=IDLE.
  - For a start edge at cycle 0, busy is high in cycles 1..N, and new hi/lo are visible from cycle N+1.
- md_op is ignored entirely while in RUN. The `stall` protocol guarantees no MD op reaches E while RUN; a bench checker flags any violation.
- stall = d_md_use & (start | busy). A `mfhi` in D therefore waits until hi/lo are final. MD ops in D never overlap a running operation.
- Arithmetic:
  - mult: signed 32x32 -> 64; hi = upper 32 bits, lo = lower 32 bits.
  - multu: same, unsigned.
  - div/divu: lo = quotient, hi = remainder.
  - div: signed, truncated toward zero; remainder takes the sign of the dividend.
  - div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero (src_b==0, div or divu): the unit still goes busy for DIV_CYCLES, but hi/lo are NOT updated at completion.
- Operand capture: src_a/src_b are sampled only on the start edge. Later changes on them do not affect the result.
- hi/lo outputs are registers, read directly by the E-stage mfhi/mflo mux.

Test Plan:
1. reset=0 mid-sequence (cycle 3 of a div) -> busy=0, hi=lo=0 immediately (before the next clk edge). After release, md_op=0 -> busy stays 0.
2. multu src_a=0xFFFFFFFF, src_b=2 -> busy=1 for exactly 5 cycles, then hi=0x00000001, lo=0xFFFFFFFE. mult -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
3. div src_a=0xFFFFFFF9 (-7), src_b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/2 -> lo=3, hi=1. div 0x80000000 / -1 -> lo=0x80000000, hi=0.
4. divu 7/0 with hi=0x11, lo=0x22 -> busy 10 cycles, then hi=0x11, lo=0x22 unchanged.
5. Stall timing:
   - mult start with d_md_use=1 (mflo in D) -> stall=1 for the start cycle plus 5 busy cycles (6 total), stall=0 the next cycle; lo holds the product.
   - d_md_use=0 during busy -> stall=0.
6. mthi src_a=0xDEADBEEF, then mtlo src_a=0x12345678 on consecutive cycles -> hi=0xDEADBEEF and lo=0x12345678 one edge after each; busy never asserts.
